// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, run/pause/lap state machine and tick
// prescaler for the stopwatch counter. Every output is driven from a flop.
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state; without
// it lap_hold is tied low and clear is ignored while running.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_clear,
    output logic run,
    output logic stop,
    output logic clr,
    output logic tick,
    output logic lap_hold
);

    localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int              PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
`ifdef STOPWATCH_LAP_EN
        ,
        LAP   = 2'd3
`endif
    } state_t;

    // Button lanes: bit 0 is start/stop, bit 1 is clear/lap.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db_level;
    logic [1:0]      db_prev;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    logic            start_ev;
    logic            clear_ev;

    state_t          state;
    state_t          state_next;
    logic            run_next;
    logic            clr_next;
    logic [PS_W-1:0] ps;
    logic            ps_wrap;

    assign btn_raw = {btn_clear, btn_start};

    // Synchronise, debounce and edge-detect both buttons.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_prev  <= '0;
            press    <= '0;
            // NOTE: the counter array is a handful of flops, so it is reset like any other register.
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Start has priority: a clear arriving in the same cycle is dropped.
    assign start_ev = press[0];
    assign clear_ev = press[1] & ~press[0];

    // Next-state decode and the clear request for the counter.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_next = state;
        clr_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ev) begin
                    state_next = RUN;
                end else if (clear_ev) begin
                    clr_next = 1'b1;
                end
            end
            RUN: begin
                if (start_ev) begin
                    state_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (clear_ev) begin
                    state_next = LAP;
`endif
                end
            end
            PAUSE: begin
                if (start_ev) begin
                    state_next = RUN;
                end else if (clear_ev) begin
                    clr_next   = 1'b1;
                    state_next = IDLE;
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (start_ev) begin
                    state_next = PAUSE;
                end else if (clear_ev) begin
                    state_next = RUN;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
`ifdef STOPWATCH_LAP_EN
        run_next = (state_next == RUN) || (state_next == LAP);
`else
        run_next = (state_next == RUN);
`endif
    end

    // State register plus registered run/clr/lap_hold taken from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            run   <= 1'b0;
            clr   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold <= 1'b0;
`endif
        end else begin
            state <= state_next;
            run   <= run_next;
            clr   <= clr_next;
`ifdef STOPWATCH_LAP_EN
            lap_hold <= (state_next == LAP);
`endif
        end
    end

`ifndef STOPWATCH_LAP_EN
    assign lap_hold = 1'b0;
`endif

    assign ps_wrap = run && (ps == PS_MAX);

    // Prescaler: advances only while running, holds through pause, and is
    // zeroed together with the clr pulse; tick/stop flag each wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps   <= '0;
            tick <= 1'b0;
            stop <= 1'b1;
        end else begin
            tick <= ps_wrap;
            stop <= ~ps_wrap;
            if (clr_next) begin
                ps <= '0;
            end else if (run) begin
                ps <= (ps == PS_MAX) ? '0 : ps + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=16
// and TICK_DIV=4. Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;
    logic run;
    logic stop;
    logic clr;
    logic tick;
    logic lap_hold;

    int   checks        = 0;
    int   errors        = 0;
    int   cyc           = 0;
    int   tick_seen     = 0;
    int   clr_seen      = 0;
    int   last_tick_cyc = -1;
    bit   cadence_on    = 1'b0;
    logic prev_clr      = 1'b0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .TICK_DIV       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .run      (run),
        .stop     (stop),
        .clr      (clr),
        .tick     (tick),
        .lap_hold (lap_hold)
    );

    always #5 clk = ~clk;

    // Advance n cycles; every cycle stop must be the inverse of tick and clr
    // must never last two cycles. Ticks and clr pulses are tallied.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (stop !== ~tick) begin
                errors++;
                $display("FAIL stop_vs_tick cyc %0d stop=%b tick=%b required stop=%b", cyc, stop, tick, ~tick);
            end
            if (clr === 1'b1) begin
                clr_seen++;
                checks++;
                if (prev_clr === 1'b1) begin
                    errors++;
                    $display("FAIL clr_width cyc %0d clr high 2 cycles, required 1", cyc);
                end
            end
            prev_clr = clr;
            if (tick === 1'b1) begin
                tick_seen++;
                if (cadence_on && last_tick_cyc >= 0) begin
                    checks++;
                    if (cyc - last_tick_cyc != 4) begin
                        errors++;
                        $display("FAIL tick_interval cyc %0d got %0d required 4", cyc, cyc - last_tick_cyc);
                    end
                end
                last_tick_cyc = cyc;
            end
        end
    endtask

    // Hold buttons until the resulting state update is visible (20 cycles).
    task automatic press(input logic s, input logic c);
        btn_start = s;
        btn_clear = c;
        step(20);
    endtask

    task automatic release_all();
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(20);
    endtask

    // Cycles until the next tick, or -1 if none within max_cycles.
    task automatic first_tick(input int max_cycles, output int d);
        d = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step(1);
            if (tick === 1'b1) begin
                d = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++;
        if ({run, stop, clr, tick, lap_hold} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_hold got %b required 01000", {run, stop, clr, tick, lap_hold});
        end
        reset = 1'b0;
        step(3);
        checks++;
        if ({run, stop, clr, tick, lap_hold} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_release got %b required 01000", {run, stop, clr, tick, lap_hold});
        end
    endtask

    task automatic test_clear_idle();
        int c0;
        c0 = clr_seen;
        btn_clear = 1'b1;
        step(19);
        checks++;
        if (clr !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle_early got %b required 0", clr);
        end
        step(1);
        checks++;
        if (clr !== 1'b1 || run !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle_pulse got clr=%b run=%b required clr=1 run=0", clr, run);
        end
        step(1);
        checks++;
        if (clr !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle_end got %b required 0", clr);
        end
        release_all();
        checks++;
        if (clr_seen - c0 != 1 || run !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle_count got %0d run=%b required 1 run=0", clr_seen - c0, run);
        end
    endtask

    task automatic test_debounce();
        btn_start = 1'b1;
        step(15);
        btn_start = 1'b0;
        step(40);
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL debounce_reject got run=%b required 0", run);
        end
        btn_start = 1'b1;
        step(19);
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL debounce_edge18 got run=%b required 0", run);
        end
        step(1);
        checks++;
        if (run !== 1'b1 || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL debounce_accept got run=%b lap_hold=%b required run=1 lap_hold=0", run, lap_hold);
        end
    endtask

    task automatic test_tick_cadence();
        int d;
        int t0;
        first_tick(8, d);
        checks++;
        if (d != 4) begin
            errors++;
            $display("FAIL first_tick got %0d required 4", d);
        end
        first_tick(8, d);
        checks++;
        if (d != 4) begin
            errors++;
            $display("FAIL second_tick got %0d required 4", d);
        end
        t0 = tick_seen;
        release_all();
        checks++;
        if (tick_seen - t0 != 5) begin
            errors++;
            $display("FAIL ticks_in_20 got %0d required 5", tick_seen - t0);
        end
        // Pause lands where the prescaler holds 2 (it showed 1 the cycle before).
        step(2);
        press(1'b1, 1'b0);
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL pause_run got %b required 0", run);
        end
        t0 = tick_seen;
        release_all();
        checks++;
        if (tick_seen - t0 != 0 || run !== 1'b0) begin
            errors++;
            $display("FAIL pause_ticks got %0d run=%b required 0 run=0", tick_seen - t0, run);
        end
        press(1'b1, 1'b0);
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL resume_run got %b required 1", run);
        end
        first_tick(8, d);
        checks++;
        if (d != 2) begin
            errors++;
            $display("FAIL resume_tick got %0d required 2", d);
        end
        first_tick(8, d);
        checks++;
        if (d != 4) begin
            errors++;
            $display("FAIL resume_next_tick got %0d required 4", d);
        end
    endtask

    task automatic test_clear_pause();
        int c0;
        int d;
        release_all();
        step(1);
        press(1'b1, 1'b0);
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL clrp_pause got run=%b required 0", run);
        end
        release_all();
        c0 = clr_seen;
        press(1'b0, 1'b1);
        checks++;
        if (clr !== 1'b1 || run !== 1'b0) begin
            errors++;
            $display("FAIL clrp_pulse got clr=%b run=%b required clr=1 run=0", clr, run);
        end
        step(1);
        checks++;
        if (clr !== 1'b0) begin
            errors++;
            $display("FAIL clrp_end got %b required 0", clr);
        end
        release_all();
        checks++;
        if (clr_seen - c0 != 1) begin
            errors++;
            $display("FAIL clrp_count got %0d required 1", clr_seen - c0);
        end
        // From IDLE after the clear the prescaler must restart at 0.
        press(1'b1, 1'b0);
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL clrp_restart got run=%b required 1", run);
        end
        first_tick(8, d);
        checks++;
        if (d != 4) begin
            errors++;
            $display("FAIL clrp_first_tick got %0d required 4", d);
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        release_all();
        step(1);
        press(1'b1, 1'b0);
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL sim_pause got run=%b required 0", run);
        end
        release_all();
        c0 = clr_seen;
        press(1'b1, 1'b1);
        checks++;
        if (run !== 1'b1 || clr !== 1'b0) begin
            errors++;
            $display("FAIL sim_start_wins got run=%b clr=%b required run=1 clr=0", run, clr);
        end
        release_all();
        checks++;
        if (clr_seen != c0 || run !== 1'b1) begin
            errors++;
            $display("FAIL sim_no_clr got %0d clr pulses run=%b required 0 run=1", clr_seen - c0, run);
        end
    endtask

    task automatic test_lap();
        int c0;
        logic exp_lap;
`ifdef STOPWATCH_LAP_EN
        exp_lap = 1'b1;
`else
        exp_lap = 1'b0;
`endif
        c0            = clr_seen;
        last_tick_cyc = -1;
        cadence_on    = 1'b1;
        press(1'b0, 1'b1);
        checks++;
        if (run !== 1'b1 || lap_hold !== exp_lap) begin
            errors++;
            $display("FAIL lap_enter got run=%b lap_hold=%b required run=1 lap_hold=%b", run, lap_hold, exp_lap);
        end
        release_all();
        press(1'b0, 1'b1);
        checks++;
        if (run !== 1'b1 || lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL lap_exit got run=%b lap_hold=%b required run=1 lap_hold=0", run, lap_hold);
        end
        release_all();
        cadence_on = 1'b0;
        checks++;
        if (clr_seen != c0) begin
            errors++;
            $display("FAIL lap_no_clr got %0d clr pulses required 0", clr_seen - c0);
        end
    endtask

    task automatic test_reset_mid_run();
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_run got %b required 1", run);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({run, stop, clr, tick, lap_hold} !== 5'b01000) begin
            errors++;
            $display("FAIL async_reset got %b required 01000", {run, stop, clr, tick, lap_hold});
        end
        step(2);
        reset = 1'b0;
        step(8);
        checks++;
        if (run !== 1'b0 || stop !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got run=%b stop=%b required run=0 stop=1", run, stop);
        end
    endtask

    initial begin
        test_reset();
        test_clear_idle();
        test_debounce();
        test_tick_cadence();
        test_clear_pause();
        test_simultaneous();
        test_lap();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, required completion");
        $fatal(1);
    end

endmodule
